// File: rtl/stream_downsize_if.sv
// Stream bundle for stream_downsize: wide multi-lane input beat and narrow output word.
// The slave modport is the converter's view; the master modport is the producer/consumer view.
interface stream_downsize_if #(
    parameter int unsigned T_DATA_WIDTH = 1,
    parameter int unsigned T_DATA_RATIO = 2
);
    logic [T_DATA_RATIO-1:0][T_DATA_WIDTH-1:0] s_data_i;
    logic [T_DATA_RATIO-1:0]                   s_keep_i;
    logic                                      s_last_i;
    logic                                      s_valid_i;
    logic                                      s_ready_o;
    logic [T_DATA_WIDTH-1:0]                   m_data_o;
    logic                                      m_last_o;
    logic                                      m_valid_o;
    logic                                      m_ready_i;

    modport slave (
        input  s_data_i, s_keep_i, s_last_i, s_valid_i, m_ready_i,
        output s_ready_o, m_data_o, m_last_o, m_valid_o
    );

    modport master (
        output s_data_i, s_keep_i, s_last_i, s_valid_i, m_ready_i,
        input  s_ready_o, m_data_o, m_last_o, m_valid_o
    );
endinterface

// File: rtl/stream_downsize.sv
// Wide-to-narrow stream converter: emits the kept lanes of each beat one word per cycle, lowest lane first.
// Define STREAM_DOWNSIZE_NULL_LAST_EN to turn a keep==0,last==1 beat into a single null word carrying last.
module stream_downsize #(
    parameter int unsigned T_DATA_WIDTH = 1,
    parameter int unsigned T_DATA_RATIO = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    stream_downsize_if.slave  bus
);
    localparam int unsigned           SEL_W = $clog2(T_DATA_RATIO);
    localparam logic [T_DATA_RATIO-1:0] ONE = T_DATA_RATIO'(1);

    logic [T_DATA_RATIO-1:0][T_DATA_WIDTH-1:0] r_hold;
    logic [T_DATA_RATIO-1:0]                   r_rem_keep;
    logic                                      r_hold_last;

    logic [T_DATA_RATIO-1:0] w_low_bit;
    logic [SEL_W-1:0]        w_sel;
    logic                    w_null;
    logic                    w_busy;
    logic                    w_one_left;
    logic                    w_in_hs;
    logic                    w_out_hs;

`ifdef STREAM_DOWNSIZE_NULL_LAST_EN
    logic r_null;
    assign w_null = r_null;
`else
    assign w_null = 1'b0;
`endif

    // Two's-complement trick isolates the lowest pending lane.
    assign w_low_bit = r_rem_keep & (~r_rem_keep + ONE);

    always_comb begin
        w_sel = '0;
        for (int unsigned i = 0; i < T_DATA_RATIO; i++) begin
            if (w_low_bit[i]) w_sel = SEL_W'(i);
        end
    end

    assign w_busy     = (|r_rem_keep) || w_null;
    assign w_one_left = ((|r_rem_keep) && (w_low_bit == r_rem_keep)) || w_null;
    assign w_out_hs   = w_busy && bus.m_ready_i;
    assign w_in_hs    = bus.s_valid_i && bus.s_ready_o;

    assign bus.m_valid_o = w_busy;
    assign bus.m_last_o  = r_hold_last && w_one_left;
    assign bus.m_data_o  = w_null ? '0 : r_hold[w_sel];
    assign bus.s_ready_o = !w_busy || (bus.m_ready_i && w_one_left);

    // A new beat overwrites the lane being retired in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold      <= '0;
            r_rem_keep  <= '0;
            r_hold_last <= 1'b0;
`ifdef STREAM_DOWNSIZE_NULL_LAST_EN
            r_null      <= 1'b0;
`endif
        end else if (w_in_hs) begin
            r_hold      <= bus.s_data_i;
            r_rem_keep  <= bus.s_keep_i;
            r_hold_last <= bus.s_last_i;
`ifdef STREAM_DOWNSIZE_NULL_LAST_EN
            r_null      <= (bus.s_keep_i == '0) && bus.s_last_i;
`endif
        end else if (w_out_hs) begin
            r_rem_keep  <= r_rem_keep & ~w_low_bit;
`ifdef STREAM_DOWNSIZE_NULL_LAST_EN
            r_null      <= 1'b0;
`endif
        end
    end
endmodule

// File: tb/tb_stream_downsize.sv
// Scoreboard bench for stream_downsize (8-bit lanes, 4 lanes per beat).
module tb_stream_downsize;
    localparam int unsigned W = 8;
    localparam int unsigned R = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    stream_downsize_if #(.T_DATA_WIDTH(W), .T_DATA_RATIO(R)) bus();

    stream_downsize #(.T_DATA_WIDTH(W), .T_DATA_RATIO(R)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic [W-1:0] d;
        logic         l;
        logic         f;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    // Monitor: compares every cycle against the queue front; pops on output handshake.
    always @(negedge clk) begin
        if (q.size() == 0) begin
            chk("idle_m_valid", {31'b0, bus.m_valid_o}, 32'd0);
            chk("idle_s_ready", {31'b0, bus.s_ready_o}, 32'd1);
        end else begin
            chk("busy_m_valid", {31'b0, bus.m_valid_o}, 32'd1);
            chk("m_data", {24'b0, bus.m_data_o}, {24'b0, q[0].d});
            chk("m_last", {31'b0, bus.m_last_o}, {31'b0, q[0].l});
            chk("busy_s_ready", {31'b0, bus.s_ready_o}, {31'b0, bus.m_ready_i && q[0].f});
            if (bus.m_valid_o && bus.m_ready_i) void'(q.pop_front());
        end
    end

    task automatic send_beat(input logic [R-1:0][W-1:0] d, input logic [R-1:0] k, input logic l);
        bit   ok;
        int   hi;
        exp_t e;
        ok = 1'b0;
        hi = -1;
        bus.s_data_i  = d;
        bus.s_keep_i  = k;
        bus.s_last_i  = l;
        bus.s_valid_i = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.s_ready_o) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            chk("accept_timeout", 32'd0, 32'd1);
            bus.s_valid_i = 1'b0;
            return;
        end
        @(posedge clk);
        for (int i = 0; i < int'(R); i++) if (k[i]) hi = i;
        for (int i = 0; i < int'(R); i++) begin
            if (k[i]) begin
                e.d = d[i];
                e.l = l && (i == hi);
                e.f = (i == hi);
                q.push_back(e);
            end
        end
`ifdef STREAM_DOWNSIZE_NULL_LAST_EN
        if (k == '0 && l) begin
            e.d = '0;
            e.l = 1'b1;
            e.f = 1'b1;
            q.push_back(e);
        end
`endif
        #1 bus.s_valid_i = 1'b0;
    endtask

    task automatic drain();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        chk("drain_timeout", {31'b0, ok}, 32'd1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_m_valid"}, {31'b0, bus.m_valid_o}, 32'd0);
        chk({tag, "_m_last"},  {31'b0, bus.m_last_o},  32'd0);
        chk({tag, "_m_data"},  {24'b0, bus.m_data_o},  32'd0);
        chk({tag, "_s_ready"}, {31'b0, bus.s_ready_o}, 32'd1);
    endtask

    initial begin
        bus.s_data_i  = '0;
        bus.s_keep_i  = '0;
        bus.s_last_i  = 1'b0;
        bus.s_valid_i = 1'b0;
        bus.m_ready_i = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs("rst_init");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Full beat with last: 11,22,33,44
        send_beat(32'h44332211, 4'b1111, 1'b1);
        drain();

        // Sparse keep: 22 then 44, no last
        send_beat(32'h44332211, 4'b1010, 1'b0);
        drain();

        // Backpressure for 3 cycles while 22 is presented
        send_beat(32'h44332211, 4'b1111, 1'b1);
        @(posedge clk);
        #1;
        bus.m_ready_i = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("bp_m_data",  {24'b0, bus.m_data_o},  32'h22);
            chk("bp_m_valid", {31'b0, bus.m_valid_o}, 32'd1);
            chk("bp_s_ready", {31'b0, bus.s_ready_o}, 32'd0);
        end
        @(posedge clk);
        #1;
        bus.m_ready_i = 1'b1;
        drain();

        // Back-to-back beats, last only on 88
        send_beat(32'h44332211, 4'b1111, 1'b0);
        send_beat(32'h88776655, 4'b1111, 1'b1);
        drain();

        // Empty beats
        send_beat(32'h0, 4'b0000, 1'b1);
        drain();
        send_beat(32'h0, 4'b0000, 1'b0);
        drain();
        repeat (3) @(posedge clk);
        #1;

        // Reset in the middle of a beat
        send_beat(32'hDDCCBBAA, 4'b1111, 1'b1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        q.delete();
        #1;
        chk_reset_outputs("rst_mid");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;

        // Recovery after reset: AA then CC with last
        send_beat(32'hDDCCBBAA, 4'b0101, 1'b1);
        drain();
        repeat (2) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end
endmodule
